// File: rtl/lnk_rr_arbiter_pkg.sv
// Shared widths, output FSM encodings and the arbitration rule for the
// two-input round-robin link arbiter.
package lnk_rr_arbiter_pkg;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;

  typedef enum logic [1:0] {
    NS_ARB_IDLE = 2'd0,
    NS_ARB_SEND = 2'd1,
    NS_ARB_DROP = 2'd2
  } arb_state_e;

  // A lone full input wins outright; on a tie the input not served last wins.
  function automatic logic pick_grant(input logic full0,
                                      input logic full1,
                                      input logic last);
    return (full0 && full1) ? !last : full1;
  endfunction

endpackage

// File: rtl/lnk_rr_arbiter_if.sv
// One four-phase message link: the sender drives addr/dat/red/req, the
// receiver answers on ack.
interface lnk_rr_arbiter_if
  import lnk_rr_arbiter_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) ();

  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output addr, output dat, output red, output req, input ack);
  modport slave  (input addr, input dat, input red, input req, output ack);

endinterface

// File: rtl/lnk_rr_arbiter_in_slot.sv
// Single-message input buffer: accepts one message from an upstream link and
// holds it until the output side reports completion through clr.
module lnk_rr_arbiter_in_slot
  import lnk_rr_arbiter_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic            i_clk,
  input  logic            reset,
  lnk_rr_arbiter_if.slave lnk,
  input  logic            clr,
  output logic            full,
  output logic [ASZ-1:0]  slot_addr,
  output logic [DSZ-1:0]  slot_dat,
  output logic [RSZ-1:0]  slot_red
);

  logic ack_q;
  logic capture;

  assign lnk.ack = ack_q;
  assign capture = lnk.req && !ack_q && !full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were just before the edge.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      full      <= 1'b0;
      slot_addr <= '0;
      slot_dat  <= '0;
      slot_red  <= '0;
    end else begin
      if (capture) begin
        slot_addr <= lnk.addr;
        slot_dat  <= lnk.dat;
        slot_red  <= lnk.red;
        full      <= 1'b1;
        ack_q     <= 1'b1;
      end else if (ack_q && !lnk.req) begin
        ack_q <= 1'b0;
      end
      // clr only arrives while full is set, so it can never meet a capture.
      if (clr) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lnk_rr_arbiter.sv
// Two-input round-robin arbiter: buffers one message per input link and
// sequences them onto a single outgoing four-phase link.
module lnk_rr_arbiter
  import lnk_rr_arbiter_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic             i_clk,
  input  logic             reset,
  output logic             ready,
  lnk_rr_arbiter_if.slave  rcv0,
  lnk_rr_arbiter_if.slave  rcv1,
  lnk_rr_arbiter_if.master snd0,
  output logic [7:0]       sent_cnt
);

  logic [1:0]     full;
  logic [1:0]     clr;
  logic [ASZ-1:0] slot_addr [2];
  logic [DSZ-1:0] slot_dat  [2];
  logic [RSZ-1:0] slot_red  [2];

  lnk_rr_arbiter_in_slot #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_slot0 (
    .i_clk     (i_clk),
    .reset     (reset),
    .lnk       (rcv0),
    .clr       (clr[0]),
    .full      (full[0]),
    .slot_addr (slot_addr[0]),
    .slot_dat  (slot_dat[0]),
    .slot_red  (slot_red[0])
  );

  lnk_rr_arbiter_in_slot #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_slot1 (
    .i_clk     (i_clk),
    .reset     (reset),
    .lnk       (rcv1),
    .clr       (clr[1]),
    .full      (full[1]),
    .slot_addr (slot_addr[1]),
    .slot_dat  (slot_dat[1]),
    .slot_red  (slot_red[1])
  );

  arb_state_e     state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q,  last_d;
  logic           req_q,   req_d;
  logic [ASZ-1:0] addr_q,  addr_d;
  logic [DSZ-1:0] dat_q,   dat_d;
  logic [RSZ-1:0] red_q,   red_d;
  logic [7:0]     cnt_q,   cnt_d;
  logic           ready_q;
  logic           sel;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    req_d   = req_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    red_d   = red_q;
    cnt_d   = cnt_q;
    clr     = 2'b00;
    sel     = pick_grant(full[0], full[1], last_q);

    unique case (state_q)
      NS_ARB_IDLE: begin
        // Waiting for ack low keeps a stale downstream ack from
        // completing the next transaction early.
        if ((full != 2'b00) && !snd0.ack) begin
          grant_d = sel;
          addr_d  = slot_addr[sel];
          dat_d   = slot_dat[sel];
          red_d   = slot_red[sel];
          req_d   = 1'b1;
          state_d = NS_ARB_SEND;
        end
      end
      NS_ARB_SEND: begin
        if (snd0.ack) begin
          req_d        = 1'b0;
          clr[grant_q] = 1'b1;
          last_d       = grant_q;
          cnt_d        = cnt_q + 8'd1;
          state_d      = NS_ARB_DROP;
        end
      end
      NS_ARB_DROP: begin
        if (!snd0.ack) begin
          state_d = NS_ARB_IDLE;
        end
      end
      default: state_d = NS_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= NS_ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      red_q   <= '0;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      red_q   <= red_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  assign snd0.addr = addr_q;
  assign snd0.dat  = dat_q;
  assign snd0.red  = red_q;
  assign snd0.req  = req_q;
  assign sent_cnt  = cnt_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_lnk_rr_arbiter.sv
// Bench for lnk_rr_arbiter: directed producers and a downstream responder,
// checked against a handshake-level model of buffering and round-robin order.
module tb_lnk_rr_arbiter;
  import lnk_rr_arbiter_pkg::*;

  localparam int ASZ = NS_ADDRESS_SIZE;
  localparam int DSZ = NS_DATA_SIZE;
  localparam int RSZ = NS_REDUN_SIZE;
  localparam int MW  = ASZ + DSZ + RSZ;

  logic       i_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready;
  logic [7:0] sent_cnt;

  lnk_rr_arbiter_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv0_l ();
  lnk_rr_arbiter_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv1_l ();
  lnk_rr_arbiter_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) snd_l ();

  lnk_rr_arbiter #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .ready    (ready),
    .rcv0     (rcv0_l),
    .rcv1     (rcv1_l),
    .snd0     (snd_l),
    .sent_cnt (sent_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model state ----------------
  logic [MW-1:0]  exp_q0 [$];
  logic [MW-1:0]  exp_q1 [$];
  logic [MW-1:0]  word_log [$];
  logic [ASZ-1:0] addr_log [$];
  int             acc [2];
  int             del [2];
  logic           last_m = 1'b1;
  logic [7:0]     cnt_m = 8'd0;
  logic           rst_prev = 1'b1;
  int             cyc = 0;
  int             rcv0_rise_cyc = 0;
  int             snd_rise_cyc = 0;

  // ---------------- downstream responder controls ----------------
  int hold_cycles = 0;
  bit rand_mode   = 1'b0;

  function automatic logic [MW-1:0] mk(input logic [ASZ-1:0] a,
                                       input logic [DSZ-1:0] d,
                                       input logic [RSZ-1:0] r);
    return {a, d, r};
  endfunction

  task automatic wait_neg();
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_msg(input int n, input logic [ASZ-1:0] a,
                          input logic [DSZ-1:0] d, input logic [RSZ-1:0] r);
    int   t;
    logic got;
    @(posedge i_clk);
    #1;
    if (n == 0) begin
      rcv0_l.addr = a; rcv0_l.dat = d; rcv0_l.red = r; rcv0_l.req = 1'b1;
      exp_q0.push_back(mk(a, d, r));
    end else begin
      rcv1_l.addr = a; rcv1_l.dat = d; rcv1_l.red = r; rcv1_l.req = 1'b1;
      exp_q1.push_back(mk(a, d, r));
    end
    t = 0; got = 1'b0;
    while (!got && t < 500) begin
      @(posedge i_clk);
      #1;
      t++;
      got = (n == 0) ? rcv0_l.ack : rcv1_l.ack;
    end
    check($sformatf("in%0d_ack_seen", n), got, 1);
    if (n == 0) rcv0_l.req = 1'b0; else rcv1_l.req = 1'b0;
    t = 0;
    while (got && t < 500) begin
      @(posedge i_clk);
      #1;
      t++;
      got = (n == 0) ? rcv0_l.ack : rcv1_l.ack;
    end
    check($sformatf("in%0d_ack_released", n), got, 0);
  endtask

  task automatic drain(input string name);
    int t;
    bit idle;
    t = 0; idle = 1'b0;
    while (!idle && t < 4000) begin
      wait_neg();
      t++;
      idle = (exp_q0.size() == 0) && (exp_q1.size() == 0) &&
             !snd_l.req && !snd_l.ack && !rcv0_l.req && !rcv1_l.req &&
             !rcv0_l.ack && !rcv1_l.ack;
    end
    check(name, idle, 1);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    reset = 1'b0;
    @(posedge i_clk);
    wait_neg();
    word_log.delete();
    addr_log.delete();
  endtask

  // Downstream receiver on snd: acks after a programmable delay.
  initial begin
    int wait_cnt;
    int cur_delay;
    wait_cnt = 0; cur_delay = 0;
    snd_l.ack = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (reset) begin
        snd_l.ack   = 1'b0;
        wait_cnt    = 0;
        hold_cycles = 0;
      end else if (snd_l.ack) begin
        if (!snd_l.req) snd_l.ack = 1'b0;
      end else if (snd_l.req) begin
        if (hold_cycles > 0) begin
          hold_cycles--;
        end else if (wait_cnt >= cur_delay) begin
          snd_l.ack = 1'b1;
          wait_cnt  = 0;
          cur_delay = rand_mode ? int'($urandom_range(0, 5)) : 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Model and compare process: samples all links on the falling edge.
  initial begin
    logic          p_req [3], c_req [3], p_ack [3], c_ack [3];
    logic [MW-1:0] p_dat [3], c_dat [3];
    logic          rst_s, pend0, pend1, g;
    logic [MW-1:0] head;
    for (int k = 0; k < 3; k++) begin
      p_req[k] = 1'b0; p_ack[k] = 1'b0; p_dat[k] = '0;
    end
    acc[0] = 0; acc[1] = 0; del[0] = 0; del[1] = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      c_req[0] = rcv0_l.req; c_ack[0] = rcv0_l.ack;
      c_dat[0] = {rcv0_l.addr, rcv0_l.dat, rcv0_l.red};
      c_req[1] = rcv1_l.req; c_ack[1] = rcv1_l.ack;
      c_dat[1] = {rcv1_l.addr, rcv1_l.dat, rcv1_l.red};
      c_req[2] = snd_l.req;  c_ack[2] = snd_l.ack;
      c_dat[2] = {snd_l.addr, snd_l.dat, snd_l.red};
      rst_s    = rst_prev;
      rst_prev = reset;
      check("ready", ready, !rst_s);
      if (rst_s) begin
        exp_q0.delete(); exp_q1.delete();
        acc[0] = 0; acc[1] = 0; del[0] = 0; del[1] = 0;
        last_m = 1'b1;
        cnt_m  = 8'd0;
        check("reset_snd_req", snd_l.req, 0);
        check("reset_acks", {rcv1_l.ack, rcv0_l.ack}, 0);
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (p_req[k] && !c_req[k])
            check($sformatf("link%0d_req_drop_needs_ack", k), p_ack[k] | c_ack[k], 1);
          if (!p_ack[k] && c_ack[k])
            check($sformatf("link%0d_ack_rise_needs_req", k), p_req[k] | c_req[k], 1);
          if (p_req[k] && c_req[k])
            check($sformatf("link%0d_data_stable", k), c_dat[k], p_dat[k]);
        end
        if (!p_req[2] && c_req[2]) begin
          check("snd_req_rise_with_ack_low", p_ack[2], 0);
          pend0 = acc[0] > del[0];
          pend1 = acc[1] > del[1];
          check("snd_has_pending_source", pend0 | pend1, 1);
          if (pend0 || pend1) begin
            g = (pend0 && pend1) ? !last_m : pend1;
            if (g == 1'b0 && exp_q0.size() > 0) begin
              head = exp_q0.pop_front();
              check("snd_msg_from_in0", c_dat[2], head);
            end else if (g == 1'b1 && exp_q1.size() > 0) begin
              head = exp_q1.pop_front();
              check("snd_msg_from_in1", c_dat[2], head);
            end
            del[g]++;
            last_m = g;
          end
          word_log.push_back(c_dat[2]);
          addr_log.push_back(snd_l.addr);
          snd_rise_cyc = cyc;
        end
        if (p_req[2] && !c_req[2]) cnt_m = cnt_m + 8'd1;
        for (int n = 0; n < 2; n++)
          if (!p_ack[n] && c_ack[n]) acc[n]++;
        if (!p_req[0] && c_req[0]) rcv0_rise_cyc = cyc;
      end
      check("sent_cnt", sent_cnt, cnt_m);
      for (int k = 0; k < 3; k++) begin
        p_req[k] = c_req[k]; p_ack[k] = c_ack[k]; p_dat[k] = c_dat[k];
      end
    end
  end

  // Directed scenarios.
  initial begin
    logic [7:0] base;
    int         t;
    rcv0_l.addr = '0; rcv0_l.dat = '0; rcv0_l.red = '0; rcv0_l.req = 1'b0;
    rcv1_l.addr = '0; rcv1_l.dat = '0; rcv1_l.red = '0; rcv1_l.req = 1'b0;

    // Reset state.
    repeat (2) @(posedge i_clk);
    wait_neg();
    check("rst_ready", ready, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    check("rst_snd_addr", snd_l.addr, 0);
    check("rst_snd_dat", snd_l.dat, 0);
    @(posedge i_clk);
    #1;
    reset = 1'b0;
    @(posedge i_clk);
    wait_neg();
    check("ready_after_release", ready, 1);

    // Single message.
    send_msg(0, 8'd5, 8'h3C, 4'd0);
    drain("single_drain");
    check("single_word", word_log[0], mk(8'd5, 8'h3C, 4'd0));
    check("single_latency", snd_rise_cyc - rcv0_rise_cyc, 2);
    check("single_sent_cnt", sent_cnt, 1);

    // Tie after reset, then a repeated tie.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      fork
        send_msg(0, 8'd1, 8'h11, 4'd1);
        send_msg(1, 8'd2, 8'h22, 4'd2);
      join
      drain("tie_drain");
    end
    check("tie_count", addr_log.size(), 4);
    check("tie_a0", addr_log[0], 1);
    check("tie_a1", addr_log[1], 2);
    check("tie_a2", addr_log[2], 1);
    check("tie_a3", addr_log[3], 2);

    // Back-pressure on a single input.
    addr_log.delete();
    base = cnt_m;
    fork
      begin
        send_msg(1, 8'h30, 8'hA0, 4'd3);
        send_msg(1, 8'h31, 8'hA1, 4'd4);
        send_msg(1, 8'h32, 8'hA2, 4'd5);
      end
      begin
        t = 0;
        while (cnt_m == base && t < 500) begin
          wait_neg();
          t++;
        end
        check("bp_first_done", cnt_m, base + 8'd1);
        hold_cycles = 20;
        repeat (8) wait_neg();
        check("bp_second_in_flight", snd_l.addr, 8'h31);
        check("bp_snd_req_held", snd_l.req, 1);
        check("bp_third_req", rcv1_l.req, 1);
        check("bp_third_waits", rcv1_l.ack, 0);
      end
    join
    drain("bp_drain");
    check("bp_count", addr_log.size(), 3);
    check("bp_a0", addr_log[0], 8'h30);
    check("bp_a1", addr_log[1], 8'h31);
    check("bp_a2", addr_log[2], 8'h32);

    // Ordering under load with random downstream delays.
    do_reset();
    rand_mode = 1'b1;
    fork
      for (int i = 0; i < 150; i++) send_msg(0, i[7:0], {1'b0, i[6:0]}, i[3:0]);
      for (int i = 0; i < 150; i++) send_msg(1, i[7:0], {1'b1, i[6:0]}, i[3:0]);
    join
    drain("load_drain");
    rand_mode = 1'b0;
    check("load_count", addr_log.size(), 300);
    check("load_sent_cnt", sent_cnt, 44);

    // Reset in the middle of a held transaction, with a second message buffered.
    hold_cycles = 50;
    fork
      send_msg(0, 8'h77, 8'h07, 4'd7);
      send_msg(1, 8'h66, 8'h06, 4'd6);
    join
    t = 0;
    while (!snd_l.req && t < 100) begin
      wait_neg();
      t++;
    end
    check("mid_snd_req_up", snd_l.req, 1);
    @(posedge i_clk);
    #1;
    reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("mid_rst_snd_req", snd_l.req, 0);
    check("mid_rst_rcv0_ack", rcv0_l.ack, 0);
    check("mid_rst_rcv1_ack", rcv1_l.ack, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_sent_cnt", sent_cnt, 0);
    @(posedge i_clk);
    #1;
    reset = 1'b0;
    @(posedge i_clk);
    wait_neg();
    addr_log.delete();
    word_log.delete();
    send_msg(1, 8'h55, 8'h5A, 4'd9);
    drain("post_rst_drain");
    check("post_rst_count", addr_log.size(), 1);
    check("post_rst_word", word_log[0], mk(8'h55, 8'h5A, 4'd9));
    check("post_rst_sent_cnt", sent_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
